// File: rtl/hcsr04_echo_model.sv
// HC-SR04 sensor emulator: answers a trig pulse with an echo pulse whose width
// encodes a programmed distance, so the driver can be exercised without hardware.
module hcsr04_echo_model #(
  parameter int unsigned TRIG_MIN_CYC   = 500,
  parameter int unsigned RESP_DELAY_CYC = 10000,
  parameter int unsigned CYC_PER_MM     = 294,
  parameter int unsigned MAX_MM         = 4000,
  parameter int unsigned NOOBJ_CYC      = 1900000,
  parameter int unsigned HOLDOFF_CYC    = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [11:0] distance,
  output logic        echo,
  output logic        busy,
  output logic        done,
  output logic        err_short
);

  localparam int unsigned MUL_MAX = 4095 * CYC_PER_MM;
  localparam int unsigned MAX_A   = (MUL_MAX > NOOBJ_CYC) ? MUL_MAX : NOOBJ_CYC;
  localparam int unsigned MAX_B   = (MAX_A > HOLDOFF_CYC) ? MAX_A : HOLDOFF_CYC;
  localparam int unsigned MAX_C   = (MAX_B > RESP_DELAY_CYC) ? MAX_B : RESP_DELAY_CYC;
  localparam int unsigned MAX_ALL = (MAX_C > TRIG_MIN_CYC) ? MAX_C : TRIG_MIN_CYC;
  localparam int          CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] TRIG_MIN = CW'(TRIG_MIN_CYC);
  // Leaving DELAY two counts early puts the first echo cycle exactly
  // RESP_DELAY_CYC cycles after the fall cycle (one for entry, one for the echo flop).
  localparam logic [CW-1:0] DLY_END  = CW'(RESP_DELAY_CYC - 2);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLDOFF_CYC);
  localparam logic [CW-1:0] NOOBJ    = CW'(NOOBJ_CYC);
  localparam logic [CW-1:0] K_MM     = CW'(CYC_PER_MM);
  localparam logic [11:0]   MAX_D    = 12'(MAX_MM);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    DELAY,
    ECHO,
    HOLDOFF
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] wid, wid_n;
  logic [11:0]   dist_q, dist_n;
  logic          echo_n, done_n, err_n;
  logic          trig_s1, trig_s, trig_s_d;

  function automatic logic [CW-1:0] echo_width(input logic [11:0] d);
    if (d == 12'd0 || d > MAX_D) return NOOBJ;
    return CW'(d) * K_MM;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_s1   <= 1'b0;
      trig_s    <= 1'b0;
      trig_s_d  <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      wid       <= '0;
      dist_q    <= '0;
      echo      <= 1'b0;
      done      <= 1'b0;
      err_short <= 1'b0;
    end else begin
      trig_s1   <= trig;
      trig_s    <= trig_s1;
      trig_s_d  <= trig_s;
      state     <= state_n;
      cnt       <= cnt_n;
      wid       <= wid_n;
      dist_q    <= dist_n;
      echo      <= echo_n;
      done      <= done_n;
      err_short <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wid_n   = wid;
    dist_n  = dist_q;
    echo_n  = echo;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        // Edge-triggered so a trig still high when holdoff ends is not a new request.
        if (trig_s && !trig_s_d) begin
          state_n = TRIG;
          cnt_n   = CW'(1);
        end
      end
      TRIG: begin
        if (trig_s) begin
          if (cnt < TRIG_MIN) cnt_n = cnt + 1'b1;
        end else if (cnt >= TRIG_MIN) begin
          dist_n  = distance;
          cnt_n   = '0;
          state_n = DELAY;
        end else begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      DELAY: begin
        if (cnt == DLY_END) begin
          wid_n   = echo_width(dist_q);
          echo_n  = 1'b1;
          cnt_n   = CW'(1);
          state_n = ECHO;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ECHO: begin
        if (cnt >= wid) begin
          echo_n  = 1'b0;
          done_n  = 1'b1;
          cnt_n   = CW'(1);
          state_n = HOLDOFF;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt >= HOLD_END) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        echo_n  = 1'b0;
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_hcsr04_echo_model.sv
// Directed bench for hcsr04_echo_model with shortened timing parameters.
module tb_hcsr04_echo_model;

  localparam int TMIN  = 5;
  localparam int RDLY  = 20;
  localparam int CPM   = 3;
  localparam int MAXMM = 100;
  localparam int NOOBJ = 400;
  localparam int HOLD  = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trig = 1'b0;
  logic [11:0] distance = 12'd0;
  logic        echo, busy, done, err_short;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0, fall_cyc = 0, done_cyc = 0;
  int rise_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int fall_drive = 0;
  logic echo_prev = 1'b0;

  hcsr04_echo_model #(
    .TRIG_MIN_CYC(TMIN),
    .RESP_DELAY_CYC(RDLY),
    .CYC_PER_MM(CPM),
    .MAX_MM(MAXMM),
    .NOOBJ_CYC(NOOBJ),
    .HOLDOFF_CYC(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trig(trig),
    .distance(distance),
    .echo(echo),
    .busy(busy),
    .done(done),
    .err_short(err_short)
  );

  always #5 clk = ~clk;

  // Edge monitor, sampled 1 ns after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (echo === 1'b1 && echo_prev !== 1'b1) begin
      rise_cyc = cyc;
      rise_cnt++;
    end
    if (echo !== 1'b1 && echo_prev === 1'b1) fall_cyc = cyc;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_short === 1'b1) err_cnt++;
    if (done === 1'b1 && err_short === 1'b1) both_cnt++;
    echo_prev = echo;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int n);
    trig = 1'b1;
    tick(n);
    trig = 1'b0;
    fall_drive = cyc;
  endtask

  task automatic wait_echo(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (echo === 1'b1) break;
      tick(1);
    end
    check(tag, 32'(echo), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int prev);
    for (int i = 0; i < 1000; i++) begin
      if (done_cnt != prev) break;
      tick(1);
    end
    check(tag, done_cnt, prev + 1);
  endtask

  // Full measurement: pulse, then check latency, width and the single done pulse.
  task automatic measure(input string tag, input logic [11:0] d, input int w);
    int d0;
    distance = d;
    d0 = done_cnt;
    pulse(8);
    wait_done({tag, "_done"}, d0);
    check({tag, "_lat"}, rise_cyc - fall_drive, RDLY + 2);
    check({tag, "_width"}, fall_cyc - rise_cyc, w);
    check({tag, "_donecyc"}, done_cyc, fall_cyc);
    tick(HOLD + 4);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int e0, r0, d0;
    tick(3);
    check("rst_echo", 32'(echo), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_short), 32'd0);
    rst = 1'b1;
    tick(3);

    // T1: nominal measurement, busy held through holdoff
    distance = 12'd85;
    d0 = done_cnt;
    pulse(8);
    tick(2);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done", d0);
    check("t1_lat", rise_cyc - fall_drive, RDLY + 2);
    check("t1_width", fall_cyc - rise_cyc, 85 * CPM);
    check("t1_donecyc", done_cyc, fall_cyc);
    tick(2);
    check("t1_hold_busy", 32'(busy), 32'd1);
    check("t1_done_once", done_cnt, d0 + 1);
    tick(HOLD + 2);
    check("t1_idle", 32'(busy), 32'd0);

    // T2: short trig rejected; exactly TRIG_MIN accepted
    e0 = err_cnt;
    r0 = rise_cnt;
    pulse(TMIN - 1);
    tick(5);
    check("t2_err", err_cnt, e0 + 1);
    check("t2_noecho", rise_cnt, r0);
    check("t2_busy", 32'(busy), 32'd0);
    distance = 12'd1;
    d0 = done_cnt;
    pulse(TMIN);
    wait_done("t2_min_done", d0);
    check("t2_min_width", fall_cyc - rise_cyc, CPM);
    check("t2_min_noerr", err_cnt, e0 + 1);
    tick(HOLD + 4);

    // T3: range boundaries
    measure("t3_zero", 12'd0, NOOBJ);
    measure("t3_over", 12'd101, NOOBJ);
    measure("t3_max", 12'd100, 100 * CPM);
    measure("t3_4001", 12'd4001, NOOBJ);

    // T4: trig during ECHO and HOLDOFF ignored; trig high across IDLE entry ignored
    distance = 12'd50;
    e0 = err_cnt;
    d0 = done_cnt;
    pulse(8);
    wait_echo("t4_rise");
    tick(10);
    pulse(8);
    wait_done("t4_done", d0);
    check("t4_width", fall_cyc - rise_cyc, 50 * CPM);
    r0 = rise_cnt;
    tick(5);
    pulse(3);
    tick(5);
    trig = 1'b1;
    tick(40);
    trig = 1'b0;
    tick(10);
    check("t4_noerr", err_cnt, e0);
    check("t4_norestart", rise_cnt, r0);
    check("t4_idle", 32'(busy), 32'd0);

    // T5: async reset mid-ECHO
    distance = 12'd20;
    d0 = done_cnt;
    pulse(8);
    wait_echo("t5_rise");
    tick(10);
    rst = 1'b0;
    #1;
    check("t5_echo_async", 32'(echo), 32'd0);
    check("t5_busy_async", 32'(busy), 32'd0);
    tick(3);
    rst = 1'b1;
    tick(2);
    check("t5_nodone", done_cnt, d0);
    measure("t5_after", 12'd20, 20 * CPM);

    // T6: distance change during DELAY does not affect the pulse in progress
    distance = 12'd85;
    d0 = done_cnt;
    pulse(8);
    tick(6);
    distance = 12'd90;
    wait_done("t6_done", d0);
    check("t6_width", fall_cyc - rise_cyc, 85 * CPM);
    tick(HOLD + 4);
    measure("t6_next", 12'd90, 90 * CPM);

    check("never_both", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
